// File: rtl/dm_abs_cmd_ctrl_pkg.sv
// Shared definitions for the abstract-command sequencer: cmderr codes, command
// field positions, legal regno window and FSM state encodings.
package dm_abs_cmd_ctrl_pkg;

  typedef enum logic [2:0] {
    CMDERR_NONE       = 3'd0,
    CMDERR_BUSY       = 3'd1,
    CMDERR_NOTSUP     = 3'd2,
    CMDERR_EXCEPT     = 3'd3,
    CMDERR_HALTRESUME = 3'd4
  } cmderr_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_DECODE, ST_REQ, ST_WAIT, ST_DONE
  } state_e;

  localparam int CMDTYPE_MSB  = 31;
  localparam int CMDTYPE_LSB  = 24;
  localparam int AARSIZE_MSB  = 22;
  localparam int AARSIZE_LSB  = 20;
  localparam int POSTEXEC_BIT = 18;
  localparam int TRANSFER_BIT = 17;
  localparam int WRITE_BIT    = 16;
  localparam int REGNO_MSB    = 15;

  localparam logic [2:0]  AARSIZE_32     = 3'd2;
  localparam logic [15:0] CSR_REGNO_MAX  = 16'h0FFF;
  localparam logic [15:0] GPR_REGNO_BASE = 16'h1000;
  localparam logic [15:0] GPR_REGNO_MAX  = 16'h101F;

endpackage

// File: rtl/dm_abs_cmd_ctrl_if.sv
// Single-outstanding debug register access port between the DM and the core.
interface dm_abs_cmd_ctrl_if #(parameter int DATA_W = 32);
  logic              dbg_reg_req_valid;
  logic              dbg_reg_req_ready;
  logic              dbg_reg_wr;
  logic              dbg_reg_is_csr;
  logic [11:0]       dbg_reg_addr;
  logic [DATA_W-1:0] dbg_reg_wdata;
  logic              dbg_rsp_valid;
  logic              dbg_rsp_err;
  logic [DATA_W-1:0] dbg_rsp_rdata;

  modport master (
    output dbg_reg_req_valid, dbg_reg_wr, dbg_reg_is_csr, dbg_reg_addr, dbg_reg_wdata,
    input  dbg_reg_req_ready, dbg_rsp_valid, dbg_rsp_err, dbg_rsp_rdata
  );

  modport slave (
    input  dbg_reg_req_valid, dbg_reg_wr, dbg_reg_is_csr, dbg_reg_addr, dbg_reg_wdata,
    output dbg_reg_req_ready, dbg_rsp_valid, dbg_rsp_err, dbg_rsp_rdata
  );
endinterface

// File: rtl/dm_abs_cmd_ctrl_decode.sv
// Combinational validation of a latched access-register command.
module dm_cmd_decode
  import dm_abs_cmd_ctrl_pkg::*;
#(
  parameter int CMD_WIDTH = 32
) (
  input  logic [CMD_WIDTH-1:0] cmd_q,
  input  logic                 core_halted,
  output cmderr_e              err_code,
  output logic                 do_access,
  output logic                 is_csr,
  output logic [11:0]          addr
);

  logic [15:0] regno;
  logic        transfer;
  logic        unsup;
  logic        in_range;
  logic        unused_bits;

  assign regno    = cmd_q[REGNO_MSB:0];
  assign transfer = cmd_q[TRANSFER_BIT];
  // bit 23 is reserved and aarpostincrement (bit 19) is never acted on
  assign unused_bits = ^{cmd_q[23], cmd_q[19]};

  assign unsup = (cmd_q[CMDTYPE_MSB:CMDTYPE_LSB] != 8'd0) || cmd_q[POSTEXEC_BIT] ||
                 (transfer && (cmd_q[AARSIZE_MSB:AARSIZE_LSB] != AARSIZE_32));
  assign in_range = (regno <= CSR_REGNO_MAX) ||
                    ((regno >= GPR_REGNO_BASE) && (regno <= GPR_REGNO_MAX));

  always_comb begin
    err_code = CMDERR_NONE;
    if (unsup || (transfer && !in_range)) err_code = CMDERR_NOTSUP;
    else if (!core_halted)                err_code = CMDERR_HALTRESUME;
  end

  assign do_access = transfer && (err_code == CMDERR_NONE);
  assign is_csr    = !regno[12];
  assign addr      = regno[11:0];

endmodule

// File: rtl/dm_abs_cmd_ctrl.sv
// Access-register abstract command sequencer. Optional response timeout is
// enabled with the DM_CMD_TIMEOUT_EN macro.
module dm_abs_cmd_ctrl
  import dm_abs_cmd_ctrl_pkg::*;
#(
  parameter int CMD_WIDTH   = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 sys_clk,
  input  logic                 sys_rstn,
  input  logic [CMD_WIDTH-1:0] command,
  input  logic                 cmd_update,
  input  logic                 cmderr_clr,
  input  logic                 core_halted,
  output logic                 cmd_busy,
  output logic [2:0]           cmderr,
  output logic                 cmd_finished,
  output logic                 cmd_read_data_valid,
  output logic [DATA_W-1:0]    cmd_read_data,
  input  logic [DATA_W-1:0]    data0,
  dm_abs_cmd_ctrl_if.master    dbg
);

  state_e                 state_q, state_d;
  cmderr_e                cmderr_q, cmderr_d;
  logic [CMD_WIDTH-1:0]   cmd_q, cmd_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;
  logic                   err_set;
  cmderr_e                err_val;
  logic                   tmo;

  cmderr_e                dec_err;
  logic                   dec_access, dec_is_csr;
  logic [11:0]            dec_addr;

  dm_cmd_decode #(.CMD_WIDTH(CMD_WIDTH)) u_decode (
    .cmd_q       (cmd_q),
    .core_halted (core_halted),
    .err_code    (dec_err),
    .do_access   (dec_access),
    .is_csr      (dec_is_csr),
    .addr        (dec_addr)
  );

`ifdef DM_CMD_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Restarts at zero on every REQ entry because DECODE always precedes REQ.
  assign cnt_d = (state_q == ST_REQ || state_q == ST_WAIT) ? cnt_q + 8'd1 : 8'd0;
  assign tmo   = (cnt_q == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk or negedge sys_rstn)
    if (!sys_rstn) cnt_q <= 8'd0;
    else           cnt_q <= cnt_d;
`else
  localparam int unused_timeout = TIMEOUT_CYC;
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_set  = 1'b0;
    err_val  = CMDERR_NONE;
    case (state_q)
      ST_IDLE: if (cmd_update) begin
        cmd_d   = command;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (cmderr_q != CMDERR_NONE) state_d = ST_DONE;
        else if (dec_err != CMDERR_NONE) begin
          err_set = 1'b1;
          err_val = dec_err;
          state_d = ST_DONE;
        end else if (!dec_access) state_d = ST_DONE;
        else begin
          wdata_d = data0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dbg.dbg_reg_req_ready) state_d = ST_WAIT;
        else if (tmo) begin
          err_set = 1'b1;
          err_val = CMDERR_EXCEPT;
          state_d = ST_DONE;
        end
      end
      ST_WAIT: begin
        if (dbg.dbg_rsp_valid) begin
          if (dbg.dbg_rsp_err) begin
            err_set = 1'b1;
            err_val = CMDERR_EXCEPT;
          end else if (!cmd_q[WRITE_BIT]) begin
            rdata_d  = dbg.dbg_rsp_rdata;
            rvalid_d = 1'b1;
          end
          state_d = ST_DONE;
        end else if (tmo) begin
          err_set = 1'b1;
          err_val = CMDERR_EXCEPT;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // First error sticks; a set in the same cycle as a clear wins over it.
  always_comb begin
    cmderr_d = cmderr_q;
    if (err_set && (cmderr_q == CMDERR_NONE || cmderr_clr))
      cmderr_d = err_val;
    else if (cmd_update && state_q != ST_IDLE && (cmderr_q == CMDERR_NONE || cmderr_clr))
      cmderr_d = CMDERR_BUSY;
    else if (cmderr_clr)
      cmderr_d = CMDERR_NONE;
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q  <= ST_IDLE;
      cmderr_q <= CMDERR_NONE;
      cmd_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmderr_q <= cmderr_d;
      cmd_q    <= cmd_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign cmd_busy            = (state_q != ST_IDLE);
  assign cmd_finished        = (state_q == ST_DONE);
  assign cmderr              = cmderr_q;
  assign cmd_read_data_valid = rvalid_q;
  assign cmd_read_data       = rdata_q;

  assign dbg.dbg_reg_req_valid = (state_q == ST_REQ);
  assign dbg.dbg_reg_wr        = (state_q == ST_REQ) && cmd_q[WRITE_BIT];
  assign dbg.dbg_reg_is_csr    = (state_q == ST_REQ) && dec_is_csr;
  assign dbg.dbg_reg_addr      = (state_q == ST_REQ) ? dec_addr : 12'h000;
  assign dbg.dbg_reg_wdata     = wdata_q;

endmodule

// File: doc/dm_abs_cmd_ctrl.md
Name: dm_abs_cmd_ctrl

Overview:
- Sequences RISC-V Debug 0.13 "access register" abstract commands.
- Inputs: the command word and the cmd_update pulse from the DM register block.
- Decodes and validates the command, then drives a single-outstanding register access handshake into the core's debug register port.
- Returns read data (cmd_read_data_valid), a cmd_finished pulse, busy status and a sticky cmderr for abstractcs.

Parameters:
- CMD_WIDTH, 32, command word width (DM_REG_WIDTH).
- DATA_W, 32, core register data width (DATA_WIDTH).
- TIMEOUT_CYC, 255, response timeout in cycles; used only with the optional feature.

Ports:
- sys_clk  in  1  clock.
- sys_rstn  in  1  asynchronous active-low reset.
- command  in  CMD_WIDTH  abstract command word; valid in the cycle cmd_update is high.
- cmd_update  in  1  one-cycle pulse: new command written.
- cmderr_clr  in  1  abstractcs.cmderr write-1-to-clear strobe.
- core_halted  in  1  hart halted status.
- cmd_busy  out  1  abstractcs.busy.
- cmderr  out  3  sticky error: 0 none, 1 busy, 2 notsupported, 3 exception, 4 haltresume.
- cmd_finished  out  1  one-cycle completion pulse.
- cmd_read_data_valid  out  1  one-cycle pulse loading data0.
- cmd_read_data  out  DATA_W  read result.
- dbg_reg_req_valid  out  1  core access request.
- dbg_reg_req_ready  in  1  core accepts request.
- dbg_reg_wr  out  1  1 = write.
- dbg_reg_is_csr  out  1  1 = CSR, 0 = GPR.
- dbg_reg_addr  out  12  CSR address or GPR index.
- dbg_reg_wdata  out  DATA_W  write data (data0).
- data0  in  DATA_W  current data0 value.
- dbg_rsp_valid  in  1  core response strobe.
- dbg_rsp_err  in  1  access faulted.
- dbg_rsp_rdata  in  DATA_W  read data.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, cmderr=0.
- Command fields: cmdtype [31:24], aarsize [22:20], postexec [18], transfer [17], write [16], regno [15:0].
- IDLE: on cmd_update, latch command into cmd_q and go to DECODE. cmd_busy goes high the cycle after cmd_update.
- DECODE (1 cycle) checks, in priority order:
  - cmderr!=0 → DONE, no access, cmderr unchanged.
  - cmdtype!=0, or postexec=1, or (transfer=1 and aarsize!=2) → cmderr=2, DONE.
  - regno outside 0x0000–0x0FFF (CSR) and 0x1000–0x101F (GPR) while transfer=1 → cmderr=2, DONE.
  - !core_halted → cmderr=4, DONE.
  - transfer=0 → DONE (no-op success).
  - Otherwise → REQ; latch data0 into dbg_reg_wdata.
- REQ:
  - dbg_reg_req_valid=1; dbg_reg_wr=write; dbg_reg_is_csr=!regno[12]; dbg_reg_addr=regno[11:0].
  - Address/data/control held stable until ready.
  - valid&ready → WAIT; valid drops the next cycle.
- WAIT: on dbg_rsp_valid:
  - err=1 → cmderr=3.
  - else if write=0 → cmd_read_data=dbg_rsp_rdata with cmd_read_data_valid pulse (same cycle as the transition).
  - Then → DONE.
  - A response arriving in the same cycle as the REQ acceptance is not legal; the core guarantees at least 1 cycle of latency.
- DONE: cmd_finished=1 for one cycle, cmd_busy=0 the following cycle, → IDLE.
- Latency: success with a zero-wait core is 4 cycles from cmd_update to cmd_finished.
- cmd_update while cmd_busy: command ignored; cmderr=1 if cmderr was 0; the running command continues.
- cmderr sticky. A set and cmderr_clr in the same cycle: set wins. cmderr_clr while busy clears normally.
- cmd_read_data holds its last value between pulses.
- Async reset mid-operation: immediate return to IDLE, request dropped. The core must tolerate an abandoned request.

Optional Feature:
- Macro: DM_CMD_TIMEOUT_EN.
- Defined:
  - 8-bit counter cleared on REQ entry, counts in REQ and WAIT.
  - On reaching TIMEOUT_CYC without the phase completing: cmderr=3, dbg_reg_req_valid dropped, → DONE.
  - A late dbg_rsp_valid in IDLE is ignored.
- Undefined: no counter; the FSM waits indefinitely.

Decomposition:
- Shared header dbg_defines.vh holds:
  - cmderr codes (CMDERR_NONE/BUSY/NOTSUP/EXCEPT/HALTRESUME);
  - command field bit positions;
  - regno range bounds (CSR_REGNO_MAX 0x0FFF, GPR_REGNO_BASE 0x1000, GPR_REGNO_MAX 0x101F);
  - FSM state encodings.
- One combinational sub-module, dm_cmd_decode: cmd_q, core_halted → err_code[2:0], do_access, is_csr, addr[11:0].

Test Plan:
- Halted core, command=0x0022_1001 (read x1), core returns 0xDEADBEEF after 2 cycles → one cmd_read_data_valid with 0xDEADBEEF, cmd_finished, cmderr=0.
- Halted core, data0=0x1234_5678, command=0x0023_0300 (write CSR mstatus) → req addr=0x300, is_csr=1, wr=1, wdata=0x12345678; no read pulse; cmd_finished.
- core_halted=0, command=0x0022_1001 → no request, cmderr=4, cmd_finished. Then cmderr_clr → cmderr=0.
- aarsize=3 (0x0033_1001), and separately regno=0x2000 → cmderr=2, no request. A following valid command with cmderr still 2 → finishes with no request.
- cmd_update during WAIT → cmderr=1, the original access completes normally, a single cmd_finished.
- With DM_CMD_TIMEOUT_EN and TIMEOUT_CYC=8, core never responds → cmderr=3 at cycle 8, cmd_finished, FSM in IDLE.
